fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 8, SHALL set the maximum wait cycles per byte request; legal range 1-15.
REQ-002 Parameter IMM_BIT, default 7, SHALL select the instruction bit that flags a following immediate byte.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 fetch_req  input  1  core requests the instruction at pc; sampled only in IDLE.
REQ-007 pc  input  8  program counter from the core; sampled with fetch_req.
REQ-008 err_clr  input  1  clears ERROR state.
REQ-009 mem_valid  input  1  external program source presents a valid byte on mem_data.
REQ-010 mem_data  input  8  program byte from the external source.
REQ-011 mem_req  output  1  byte request to the external source.
REQ-012 mem_addr  output  8  address of the requested byte.
REQ-013 ins_out  output  8  captured instruction byte.
REQ-014 imm_out  output  8  captured immediate byte; 0 when none fetched.
REQ-015 ins_valid  output  1  one-cycle pulse: ins_out/imm_out are complete.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 timeout_err  output  1  high while in ERROR.

Function
REQ-018 FSM states SHALL be IDLE, REQ_INS, REQ_IMM, DONE, ERROR.
REQ-019 IDLE: fetch_req=1 -> latch pc into address register, clear wait counter, go REQ_INS; else stay.
REQ-020 REQ_INS/REQ_IMM: mem_req=1 and mem_addr=address register, combinationally from state.
REQ-021 REQ_INS with mem_valid=1 -> capture mem_data into ins_out; if mem_data[IMM_BIT]=1, increment address (8'hFF wraps to 8'h00), clear wait counter, go REQ_IMM; else clear imm_out, go DONE.
REQ-022 REQ_IMM with mem_valid=1 -> capture mem_data into imm_out, go DONE.
REQ-023 Wait counter (4 bits) SHALL increment each REQ_INS/REQ_IMM cycle with mem_valid=0; when counter equals TIMEOUT-1 and mem_valid=0, go ERROR.
REQ-024 mem_valid=1 on the timeout-boundary cycle SHALL win: byte captured, no ERROR.
REQ-025 DONE: ins_valid=1 for exactly one cycle, then IDLE unconditionally.
REQ-026 ERROR: timeout_err=1, mem_req=0, ins_valid never asserted; err_clr=1 -> IDLE.
REQ-027 fetch_req SHALL be ignored outside IDLE; mem_valid ignored outside REQ_INS/REQ_IMM.
REQ-028 Latency: fetch_req at edge N -> mem_req high in cycle N+1; mem_valid sampled at edge M -> ins_valid high in cycle M+1 (no immediate) or REQ_IMM in cycle M+1.
REQ-029 ins_out and imm_out SHALL hold their values until the next capture.
REQ-030 mem_addr SHALL equal the address register in all states (value is don't-care to the source when mem_req=0).

Reset
REQ-031 rst_n low SHALL immediately force IDLE and zero ins_out, imm_out, address register, wait counter; mem_req, ins_valid, busy, timeout_err low.
REQ-032 Reset asserted mid-fetch SHALL abandon the fetch with no ins_valid pulse; first fetch_req after release starts a fresh fetch.

Verification
REQ-033 pc=8'h10, fetch_req 1 cycle, mem_valid next cycle with 8'h05 -> mem_addr=8'h10, ins_out=8'h05, imm_out=0, ins_valid one pulse, busy low after.
REQ-034 pc=8'h20, bytes 8'h83 then 8'h5A with 2-cycle gap -> mem_addr 8'h20 then 8'h21, ins_out=8'h83, imm_out=8'h5A, single ins_valid pulse.
REQ-035 pc=8'hFF, byte 8'h80 then 8'h11 -> second mem_addr=8'h00, imm_out=8'h11.
REQ-036 TIMEOUT=8, mem_valid never asserted -> ERROR after 8 request cycles, timeout_err=1, mem_req=0; err_clr -> IDLE; valid on 8th cycle -> capture, no error.
REQ-037 rst_n pulsed low during REQ_IMM -> outputs zero asynchronously, no ins_valid; fetch_req after release fetches normally.
REQ-038 fetch_req held high continuously -> back-to-back fetches, each starting only from IDLE, exactly one ins_valid per fetch.

Source files
------------

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Fetches one instruction byte, plus an optional immediate byte,
//               from an external byte source with a per-byte wait timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int TIMEOUT = 8,
    parameter int IMM_BIT = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fetch_req,
    input  logic [7:0] pc,
    input  logic       err_clr,
    input  logic       mem_valid,
    input  logic [7:0] mem_data,
    output logic       mem_req,
    output logic [7:0] mem_addr,
    output logic [7:0] ins_out,
    output logic [7:0] imm_out,
    output logic       ins_valid,
    output logic       busy,
    output logic       timeout_err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_REQ_INS = 3'd1;
    localparam logic [2:0] S_REQ_IMM = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;
    localparam logic [2:0] S_ERROR   = 3'd4;

    localparam logic [3:0] c_wait_last = 4'(TIMEOUT - 1);

    logic [2:0] r_state;
    logic [7:0] r_addr;
    logic [7:0] r_ins;
    logic [7:0] r_imm;
    logic [3:0] r_wait;
    logic       w_req_state;
    logic       w_expire;

    assign w_req_state = (r_state == S_REQ_INS) || (r_state == S_REQ_IMM);
    // A byte arriving on the last allowed cycle takes priority over the timeout.
    assign w_expire    = !mem_valid && (r_wait == c_wait_last);

    assign mem_req     = w_req_state;
    assign mem_addr    = r_addr;
    assign ins_out     = r_ins;
    assign imm_out     = r_imm;
    assign ins_valid   = (r_state == S_DONE);
    assign busy        = (r_state != S_IDLE);
    assign timeout_err = (r_state == S_ERROR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= 8'h00;
            r_ins   <= 8'h00;
            r_imm   <= 8'h00;
            r_wait  <= 4'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (fetch_req) begin
                        r_addr  <= pc;
                        r_wait  <= 4'h0;
                        r_state <= S_REQ_INS;
                    end
                end
                S_REQ_INS: begin
                    if (mem_valid) begin
                        r_ins <= mem_data;
                        if (mem_data[IMM_BIT]) begin
                            r_addr  <= r_addr + 8'h01;
                            r_wait  <= 4'h0;
                            r_state <= S_REQ_IMM;
                        end else begin
                            r_imm   <= 8'h00;
                            r_state <= S_DONE;
                        end
                    end else if (w_expire) begin
                        r_state <= S_ERROR;
                    end else begin
                        r_wait <= r_wait + 4'h1;
                    end
                end
                S_REQ_IMM: begin
                    if (mem_valid) begin
                        r_imm   <= mem_data;
                        r_state <= S_DONE;
                    end else if (w_expire) begin
                        r_state <= S_ERROR;
                    end else begin
                        r_wait <= r_wait + 4'h1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                S_ERROR: begin
                    if (err_clr) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Randomised fetch transactions against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    localparam int TIMEOUT = 8;
    localparam int IMM_BIT = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fetch_req = 1'b0;
    logic [7:0] pc = 8'h00;
    logic       err_clr = 1'b0;
    logic       mem_valid = 1'b0;
    logic [7:0] mem_data = 8'h00;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic [7:0] ins_out;
    logic [7:0] imm_out;
    logic       ins_valid;
    logic       busy;
    logic       timeout_err;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;
    int exp_pulses = 0;

    // Transaction-level expectations carried between fetches.
    logic [7:0] exp_ins  = 8'h00;
    logic [7:0] exp_imm  = 8'h00;
    logic [7:0] exp_addr = 8'h00;

    fetch_sequencer #(.TIMEOUT(TIMEOUT), .IMM_BIT(IMM_BIT)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .pc(pc),
        .err_clr(err_clr), .mem_valid(mem_valid), .mem_data(mem_data),
        .mem_req(mem_req), .mem_addr(mem_addr), .ins_out(ins_out),
        .imm_out(imm_out), .ins_valid(ins_valid), .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ins_valid) pulses <= pulses + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle();
        chk("idle_busy", busy, 0);
        chk("idle_req", mem_req, 0);
        chk("idle_valid", ins_valid, 0);
        chk("idle_err", timeout_err, 0);
        chk("idle_ins", ins_out, exp_ins);
        chk("idle_imm", imm_out, exp_imm);
        chk("idle_addr", mem_addr, exp_addr);
    endtask

    // Serves one byte request: gap empty cycles then the byte, unless the
    // gap reaches TIMEOUT, in which case the source never answers.
    task automatic serve_byte(input logic [7:0] addr, input logic [7:0] data,
                              input int gap, output bit got);
        got = 0;
        for (int k = 0; k < TIMEOUT; k++) begin
            @(negedge clk);
            chk("req_mem_req", mem_req, 1);
            chk("req_addr", mem_addr, addr);
            chk("req_busy", busy, 1);
            chk("req_valid", ins_valid, 0);
            chk("req_err", timeout_err, 0);
            fetch_req = 1'($urandom_range(0, 1));
            if (k == gap) begin
                mem_valid = 1'b1;
                mem_data  = data;
            end else begin
                mem_valid = 1'b0;
                mem_data  = 8'($urandom);
            end
            @(posedge clk);
            if (k == gap) begin
                got = 1;
                break;
            end
        end
    endtask

    // Entered and left at a negedge with the DUT in IDLE.
    task automatic do_fetch(input logic [7:0] a, input logic [7:0] ins,
                            input logic [7:0] imm, input int g1, input int g2,
                            input bit hold);
        bit got;
        logic [7:0] a1;
        a1 = a + 8'h01;
        fetch_req = 1'b1;
        pc        = a;
        @(posedge clk);
        exp_addr = a;
        serve_byte(a, ins, g1, got);
        if (got) begin
            exp_ins = ins;
            if (ins[IMM_BIT]) begin
                exp_addr = a1;
                serve_byte(a1, imm, g2, got);
                if (got) exp_imm = imm;
            end else begin
                exp_imm = 8'h00;
            end
        end
        @(negedge clk);
        mem_valid = 1'b0;
        mem_data  = 8'($urandom);
        chk("post_req", mem_req, 0);
        chk("post_busy", busy, 1);
        if (got) begin
            fetch_req = hold;
            exp_pulses++;
            chk("done_valid", ins_valid, 1);
            chk("done_err", timeout_err, 0);
            chk("done_ins", ins_out, exp_ins);
            chk("done_imm", imm_out, exp_imm);
        end else begin
            fetch_req = 1'b0;
            chk("err_flag", timeout_err, 1);
            chk("err_valid", ins_valid, 0);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                chk("err_hold", timeout_err, 1);
            end
            err_clr = 1'b1;
            @(negedge clk);
            err_clr = 1'b0;
        end
        @(negedge clk);
        check_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_idle();
        rst_n = 1'b1;
        @(negedge clk);
        check_idle();

        do_fetch(8'h10, 8'h05, 8'h00, 0, 0, 0);
        do_fetch(8'h20, 8'h83, 8'h5A, 0, 2, 0);
        do_fetch(8'hFF, 8'h80, 8'h11, 1, 0, 0);
        do_fetch(8'h30, 8'h01, 8'h00, TIMEOUT, 0, 0);
        do_fetch(8'h31, 8'h02, 8'h00, TIMEOUT - 1, 0, 0);
        do_fetch(8'h32, 8'h81, 8'h44, TIMEOUT - 1, TIMEOUT, 0);
        do_fetch(8'h33, 8'h85, 8'h66, 0, TIMEOUT - 1, 0);

        // Reset asserted while the immediate byte is outstanding.
        fetch_req = 1'b1;
        pc        = 8'h40;
        @(posedge clk);
        @(negedge clk);
        fetch_req = 1'b0;
        mem_valid = 1'b1;
        mem_data  = 8'h9C;
        @(posedge clk);
        @(negedge clk);
        mem_valid = 1'b0;
        chk("rst_pre_addr", mem_addr, 8'h41);
        #2 rst_n = 1'b0;
        #1;
        exp_ins  = 8'h00;
        exp_imm  = 8'h00;
        exp_addr = 8'h00;
        check_idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle();
        do_fetch(8'h50, 8'h8F, 8'hA5, 1, 1, 0);

        // Back-to-back fetches with fetch_req held high between them.
        for (int i = 0; i < 4; i++)
            do_fetch(8'($urandom), 8'($urandom), 8'($urandom),
                     $urandom_range(0, TIMEOUT - 1), $urandom_range(0, TIMEOUT - 1), i < 3);

        for (int i = 0; i < 40; i++)
            do_fetch(8'($urandom), 8'($urandom), 8'($urandom),
                     $urandom_range(0, TIMEOUT), $urandom_range(0, TIMEOUT),
                     $urandom_range(0, 3) == 0);

        fetch_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("pulse_count", pulses, exp_pulses);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
